// File: rtl/wbuf_recv.sv
// wbuf_recv: packs the weight byte stream read from SRAM into LANES-byte
// words for the PE array. Bytes are steered by the lane index that came with
// the read strobe, which is delayed to line up with the SRAM read data. A
// finished group goes into a two-entry queue: an output register plus a skid
// register. The queue drains through a valid/ready handshake.
module wbuf_recv #(
  parameter int DW     = 8,
  parameter int LANES  = 8,
  parameter int RD_LAT = 1
) (
  input  logic                CLK,
  input  logic                RSTL,
  input  logic                WBUF_EN,
  input  logic [2:0]          cnt,
  input  logic [DW-1:0]       RDATA,
  input  logic                W_READY,
  output logic [DW*LANES-1:0] W_OUT,
  output logic                W_VALID,
  output logic [7:0]          GRP_CNT,
  output logic                OVF,
  output logic                MISS,
  output logic                BUSY
);

  // The lane index is exactly 3 bits wide, so LANES has to be 8.
  localparam int IW = 3;

  // Delay line that aligns each strobe and its lane index with RDATA.
  logic [RD_LAT-1:0]         en_pipe_q;
  logic [RD_LAT-1:0][IW-1:0] idx_pipe_q;
  logic                      cap_en;
  logic [IW-1:0]             cap_idx;

  // Fill register and lane mask for the group being assembled.
  logic [LANES-1:0][DW-1:0]  fill_q, fill_d;
  logic [LANES-1:0]          mask_q, mask_d;

  // The group as it would look with this cycle's byte merged in.
  logic [LANES-1:0][DW-1:0]  grp_word;
  logic [LANES-1:0]          grp_mask;
  logic                      complete;

  // Output register, skid register and status.
  logic [LANES-1:0][DW-1:0]  out_q, out_d;
  logic                      out_valid_q, out_valid_d;
  logic [LANES-1:0][DW-1:0]  skid_q, skid_d;
  logic                      skid_full_q, skid_full_d;
  logic [7:0]                grp_cnt_q, grp_cnt_d;
  logic                      ovf_q, ovf_d;
  logic                      miss_q, miss_d;
  logic                      drain;
  logic                      out_free;

  // Shift the strobe and lane index down the delay line. The line keeps
  // running whatever the queue is doing, because the SRAM will return the
  // data anyway.
  always_ff @(posedge CLK) begin
    if (RSTL) begin
      en_pipe_q  <= '0;
      idx_pipe_q <= '0;
    end else begin
      en_pipe_q[0]  <= WBUF_EN;
      idx_pipe_q[0] <= cnt;
      for (int i = 1; i < RD_LAT; i++) begin
        en_pipe_q[i]  <= en_pipe_q[i-1];
        idx_pipe_q[i] <= idx_pipe_q[i-1];
      end
    end
  end

  assign cap_en  = en_pipe_q[RD_LAT-1];
  assign cap_idx = idx_pipe_q[RD_LAT-1];

  // Merge the arriving byte into the fill register. The last lane closes
  // the group, and fill and mask restart from zero on that same edge, so
  // lanes that are never written in the next group read as zero.
  always_comb begin
    grp_word = fill_q;
    grp_mask = mask_q;
    complete = 1'b0;
    fill_d   = fill_q;
    mask_d   = mask_q;
    if (cap_en) begin
      grp_word[cap_idx] = RDATA;
      grp_mask[cap_idx] = 1'b1;
      if (cap_idx == IW'(LANES - 1)) begin
        complete = 1'b1;
        fill_d   = '0;
        mask_d   = '0;
      end else begin
        fill_d = grp_word;
        mask_d = grp_mask;
      end
    end
  end

  // Queue control. The skid entry is older than any group completing now,
  // so it always moves into the output register first. A new group lands
  // in the skid only when the skid will be empty after this edge.
  // Otherwise the group is dropped and flagged.
  always_comb begin
    drain       = out_valid_q & W_READY;
    out_free    = ~out_valid_q | drain;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    grp_cnt_d   = grp_cnt_q;
    ovf_d       = ovf_q;
    miss_d      = miss_q | (complete & ~(&grp_mask));

    if (out_free) begin
      if (skid_full_q) begin
        out_d       = skid_q;
        out_valid_d = 1'b1;
        grp_cnt_d   = grp_cnt_q + 8'd1;
        skid_full_d = complete;
        if (complete) begin
          skid_d = grp_word;
        end
      end else if (complete) begin
        out_d       = grp_word;
        out_valid_d = 1'b1;
        grp_cnt_d   = grp_cnt_q + 8'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (complete) begin
      if (!skid_full_q) begin
        skid_d      = grp_word;
        skid_full_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Register the fill state, the queue and the sticky flags. Reset drops
  // any group that is partly assembled or waiting in the queue.
  always_ff @(posedge CLK) begin
    if (RSTL) begin
      fill_q      <= '0;
      mask_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      grp_cnt_q   <= 8'd0;
      ovf_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      mask_q      <= mask_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      skid_q      <= skid_d;
      skid_full_q <= skid_full_d;
      grp_cnt_q   <= grp_cnt_d;
      ovf_q       <= ovf_d;
      miss_q      <= miss_d;
    end
  end

  assign W_OUT   = out_q;
  assign W_VALID = out_valid_q;
  assign GRP_CNT = grp_cnt_q;
  assign OVF     = ovf_q;
  assign MISS    = miss_q;
  assign BUSY    = (|en_pipe_q) | (|mask_q) | skid_full_q;

endmodule

// File: tb/tb_wbuf_recv.sv
// Testbench for wbuf_recv. It runs two instances side by side, one with
// RD_LAT=1 and one with RD_LAT=3, from the same strobe stream. Each instance
// has its own SRAM read-latency pipe. A group-level reference model (lane
// array, mask and a depth-2 FIFO) predicts every output on every cycle.
module tb_wbuf_recv;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [2:0] idx;
    logic [7:0] dat;
    logic       rdy;
    logic [3:0] tag;
  } stim_t;

  int checks = 0;
  int failures = 0;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RSTL, WBUF_EN, W_READY;
  logic [2:0] cnt;
  logic [7:0] rd_byte;

  // SRAM models: the byte offered with a strobe appears RD_LAT cycles later.
  logic [7:0]      sram_l1_q;
  logic [2:0][7:0] sram_l3_q;
  always_ff @(posedge CLK) begin
    sram_l1_q <= rd_byte;
    sram_l3_q <= {sram_l3_q[1:0], rd_byte};
  end

  logic [1:0][63:0] dout;
  logic [1:0]       dvalid, dovf, dmiss, dbusy;
  logic [1:0][7:0]  dgrp;

  wbuf_recv #(.DW(8), .LANES(8), .RD_LAT(1)) dut_lat1 (
    .CLK(CLK), .RSTL(RSTL), .WBUF_EN(WBUF_EN), .cnt(cnt), .RDATA(sram_l1_q),
    .W_READY(W_READY), .W_OUT(dout[0]), .W_VALID(dvalid[0]), .GRP_CNT(dgrp[0]),
    .OVF(dovf[0]), .MISS(dmiss[0]), .BUSY(dbusy[0])
  );

  wbuf_recv #(.DW(8), .LANES(8), .RD_LAT(3)) dut_lat3 (
    .CLK(CLK), .RSTL(RSTL), .WBUF_EN(WBUF_EN), .cnt(cnt), .RDATA(sram_l3_q[2]),
    .W_READY(W_READY), .W_OUT(dout[1]), .W_VALID(dvalid[1]), .GRP_CNT(dgrp[1]),
    .OVF(dovf[1]), .MISS(dmiss[1]), .BUSY(dbusy[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // ---------------- reference model ----------------
  int          cyc = 0;
  logic        hen  [8];
  logic [2:0]  hidx [8];
  logic [7:0]  hdat [8];
  logic [7:0]  mfill [2][8];
  logic [7:0]  mmask [2];
  logic [63:0] mq [2][2];
  int          mqn [2];
  logic [7:0]  mgrp [2];
  logic        movf [2];
  logic        mmiss [2];
  logic        mbusy [2];

  always @(posedge CLK) begin
    int          ps;
    logic        en, pop, push;
    logic [2:0]  idx;
    logic [7:0]  dat;
    logic [63:0] word;
    for (int k = 0; k < 2; k++) begin
      if (RSTL) begin
        for (int j = 0; j < 8; j++) mfill[k][j] = 8'h00;
        mmask[k] = 8'h00; mqn[k] = 0; mgrp[k] = 8'd0;
        movf[k] = 1'b0; mmiss[k] = 1'b0;
        mq[k][0] = 64'h0; mq[k][1] = 64'h0;
      end else begin
        ps   = (cyc % 8 - lat_of(k) + 8) % 8;
        en   = hen[ps];
        idx  = hidx[ps];
        dat  = hdat[ps];
        push = 1'b0;
        word = 64'h0;
        pop  = (mqn[k] != 0) && W_READY;
        if (en) begin
          mfill[k][idx] = dat;
          mmask[k][idx] = 1'b1;
          if (idx == 3'd7) begin
            for (int j = 0; j < 8; j++) word[j*8 +: 8] = mfill[k][j];
            if (mmask[k] != 8'hFF) mmiss[k] = 1'b1;
            for (int j = 0; j < 8; j++) mfill[k][j] = 8'h00;
            mmask[k] = 8'h00;
            push = 1'b1;
          end
        end
        if (pop) begin
          mq[k][0] = mq[k][1];
          mqn[k]   = mqn[k] - 1;
          if (mqn[k] != 0) mgrp[k] = mgrp[k] + 8'd1;
        end
        if (push) begin
          if (mqn[k] < 2) begin
            mq[k][mqn[k]] = word;
            mqn[k] = mqn[k] + 1;
            if (mqn[k] == 1) mgrp[k] = mgrp[k] + 8'd1;
          end else begin
            movf[k] = 1'b1;
          end
        end
      end
    end
    if (RSTL) for (int j = 0; j < 8; j++) hen[j] = 1'b0;
    hen[cyc % 8]  = RSTL ? 1'b0 : WBUF_EN;
    hidx[cyc % 8] = cnt;
    hdat[cyc % 8] = rd_byte;
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      mbusy[k] = (mmask[k] != 8'h00) || (mqn[k] == 2);
      for (int d = 1; d <= lat_of(k); d++)
        if (hen[(cyc + 8 - d) % 8]) mbusy[k] = 1'b1;
    end
  end

  // Observed and predicted views: {valid, grp_cnt, ovf, miss, busy}.
  logic [1:0][11:0] act_st, exp_st;
  logic [1:0][63:0] act_out, exp_out;
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      act_st[k]  = {dvalid[k], dgrp[k], dovf[k], dmiss[k], dbusy[k]};
      act_out[k] = dvalid[k] ? dout[k] : 64'h0;
      exp_st[k]  = {(mqn[k] != 0), mgrp[k], movf[k], mmiss[k], mbusy[k]};
      exp_out[k] = (mqn[k] != 0) ? mq[k][0] : 64'h0;
    end
  end

  // ---------------- stimulus plumbing ----------------
  stim_t       sq[$];
  logic [63:0] got [2][8];
  int          ng [2];
  int          firstv [2];
  logic [11:0] snap [2][4];

  function automatic stim_t mk(input logic rst, input logic en, input logic [2:0] idx,
                               input logic [7:0] dat, input logic rdy, input logic [3:0] tag);
    stim_t s;
    s.rst = rst; s.en = en; s.idx = idx; s.dat = dat; s.rdy = rdy; s.tag = tag;
    return s;
  endfunction

  task automatic add_reset(input int n, input logic [3:0] tag);
    for (int i = 0; i < n; i++)
      sq.push_back(mk(1'b1, 1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom),
                      (i == n - 1) ? tag : 4'd0));
  endtask

  task automatic add_idle(input int n, input logic rdy, input logic [3:0] tag);
    for (int i = 0; i < n; i++)
      sq.push_back(mk(1'b0, 1'b0, 3'($urandom), 8'($urandom), rdy, (i == n - 1) ? tag : 4'd0));
  endtask

  task automatic add_strobe(input logic [2:0] idx, input logic [7:0] dat, input logic rdy);
    sq.push_back(mk(1'b0, 1'b1, idx, dat, rdy, 4'd0));
  endtask

  task automatic add_group(input logic [63:0] w, input logic rdy);
    for (int l = 0; l < 8; l++) add_strobe(3'(l), w[l*8 +: 8], rdy);
  endtask

  task automatic begin_test();
    sq.delete();
    for (int k = 0; k < 2; k++) begin
      ng[k] = 0;
      firstv[k] = -1;
      for (int t = 0; t < 4; t++) snap[k][t] = 12'hxxx;
    end
  endtask

  task automatic drive(input stim_t s);
    RSTL = s.rst; WBUF_EN = s.en; cnt = s.idx; rd_byte = s.dat; W_READY = s.rdy;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    begin_test();
    add_reset(3, 4'd0);
    foreach (sq[i]) begin
      drive(sq[i]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_st[k] !== 12'h000) begin
          failures++;
          $display("[TB] FAIL reset_state lat=%0d got=%h exp=000", lat_of(k), act_st[k]);
        end
        checks++;
        if (dout[k] !== 64'h0) begin
          failures++;
          $display("[TB] FAIL reset_wout lat=%0d got=%h exp=0", lat_of(k), dout[k]);
        end
      end
    end
  endtask

  task automatic test_basic();
    begin_test();
    add_reset(2, 4'd0);
    add_group(64'h1716151413121110, 1'b1);
    add_idle(6, 1'b1, 4'd0);
    foreach (sq[i]) begin
      for (int k = 0; k < 2; k++)
        if (sq[i].rdy && !sq[i].rst && dvalid[k] && ng[k] < 8) begin got[k][ng[k]] = dout[k]; ng[k]++; end
      drive(sq[i]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_st[k] !== exp_st[k]) begin
          failures++;
          $display("[TB] FAIL basic_state lat=%0d got=%h exp=%h", lat_of(k), act_st[k], exp_st[k]);
        end
        checks++;
        if (act_out[k] !== exp_out[k]) begin
          failures++;
          $display("[TB] FAIL basic_wout lat=%0d got=%h exp=%h", lat_of(k), act_out[k], exp_out[k]);
        end
        if (dvalid[k] && firstv[k] < 0) firstv[k] = i;
      end
    end
    // The cnt=7 strobe is entry 9; the sample after entry i shows cycle i+1.
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (firstv[k] - 9 + 1 !== lat_of(k) + 1) begin
        failures++;
        $display("[TB] FAIL basic_latency lat=%0d got=%0d exp=%0d", lat_of(k), firstv[k] - 8, lat_of(k) + 1);
      end
      checks++;
      if (ng[k] !== 1 || got[k][0] !== 64'h1716151413121110) begin
        failures++;
        $display("[TB] FAIL basic_word lat=%0d count=%0d got=%h exp=1716151413121110", lat_of(k), ng[k], got[k][0]);
      end
      checks++;
      if (act_st[k] !== {1'b0, 8'd1, 3'b000}) begin
        failures++;
        $display("[TB] FAIL basic_end lat=%0d got=%h exp=008", lat_of(k), act_st[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] g [3];
    begin_test();
    for (int j = 0; j < 3; j++) g[j] = {$urandom, $urandom};
    add_reset(2, 4'd0);
    for (int j = 0; j < 3; j++) add_group(g[j], 1'b0);
    add_idle(6, 1'b0, 4'd1);
    add_idle(10, 1'b1, 4'd0);
    foreach (sq[i]) begin
      for (int k = 0; k < 2; k++)
        if (sq[i].rdy && !sq[i].rst && dvalid[k] && ng[k] < 8) begin got[k][ng[k]] = dout[k]; ng[k]++; end
      drive(sq[i]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_st[k] !== exp_st[k]) begin
          failures++;
          $display("[TB] FAIL bp_state lat=%0d got=%h exp=%h", lat_of(k), act_st[k], exp_st[k]);
        end
        checks++;
        if (act_out[k] !== exp_out[k]) begin
          failures++;
          $display("[TB] FAIL bp_wout lat=%0d got=%h exp=%h", lat_of(k), act_out[k], exp_out[k]);
        end
        if (sq[i].tag != 4'd0) snap[k][sq[i].tag] = act_st[k];
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (snap[k][1] !== {1'b1, 8'd1, 3'b101}) begin
        failures++;
        $display("[TB] FAIL bp_stalled lat=%0d got=%h exp=80d", lat_of(k), snap[k][1]);
      end
      checks++;
      if (ng[k] !== 2 || got[k][0] !== g[0] || got[k][1] !== g[1]) begin
        failures++;
        $display("[TB] FAIL bp_order lat=%0d count=%0d got=%h,%h exp=%h,%h",
                 lat_of(k), ng[k], got[k][0], got[k][1], g[0], g[1]);
      end
      checks++;
      if (act_st[k] !== {1'b0, 8'd2, 3'b100}) begin
        failures++;
        $display("[TB] FAIL bp_end lat=%0d got=%h exp=014", lat_of(k), act_st[k]);
      end
    end
  endtask

  task automatic test_incomplete();
    logic [63:0] g;
    begin_test();
    g = {$urandom, $urandom};
    add_reset(2, 4'd0);
    add_strobe(3'd0, 8'hAA, 1'b1);
    add_strobe(3'd1, 8'hAA, 1'b1);
    add_strobe(3'd7, 8'hAA, 1'b1);
    add_idle(6, 1'b1, 4'd0);
    add_group(g, 1'b1);
    add_idle(6, 1'b1, 4'd0);
    foreach (sq[i]) begin
      for (int k = 0; k < 2; k++)
        if (sq[i].rdy && !sq[i].rst && dvalid[k] && ng[k] < 8) begin got[k][ng[k]] = dout[k]; ng[k]++; end
      drive(sq[i]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_st[k] !== exp_st[k]) begin
          failures++;
          $display("[TB] FAIL miss_state lat=%0d got=%h exp=%h", lat_of(k), act_st[k], exp_st[k]);
        end
        checks++;
        if (act_out[k] !== exp_out[k]) begin
          failures++;
          $display("[TB] FAIL miss_wout lat=%0d got=%h exp=%h", lat_of(k), act_out[k], exp_out[k]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ng[k] !== 2 || got[k][0] !== 64'hAA000000_0000AAAA || got[k][1] !== g) begin
        failures++;
        $display("[TB] FAIL miss_words lat=%0d count=%0d got=%h,%h exp=aa0000000000aaaa,%h",
                 lat_of(k), ng[k], got[k][0], got[k][1], g);
      end
      checks++;
      if (act_st[k] !== {1'b0, 8'd2, 3'b010}) begin
        failures++;
        $display("[TB] FAIL miss_end lat=%0d got=%h exp=012", lat_of(k), act_st[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] g, h;
    begin_test();
    g = {$urandom, $urandom};
    h = {$urandom, 32'h0};
    add_reset(2, 4'd0);
    for (int l = 0; l < 4; l++) add_strobe(3'(l), 8'($urandom_range(1, 255)), 1'b1);
    add_idle(3, 1'b1, 4'd1);
    add_reset(1, 4'd2);
    add_group(g, 1'b1);
    add_idle(6, 1'b1, 4'd3);
    for (int l = 0; l < 4; l++) add_strobe(3'(l), 8'($urandom_range(1, 255)), 1'b1);
    add_idle(3, 1'b1, 4'd0);
    add_reset(1, 4'd0);
    for (int l = 4; l < 8; l++) add_strobe(3'(l), h[l*8 +: 8], 1'b1);
    add_idle(6, 1'b1, 4'd0);
    foreach (sq[i]) begin
      for (int k = 0; k < 2; k++)
        if (sq[i].rdy && !sq[i].rst && dvalid[k] && ng[k] < 8) begin got[k][ng[k]] = dout[k]; ng[k]++; end
      drive(sq[i]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_st[k] !== exp_st[k]) begin
          failures++;
          $display("[TB] FAIL rstmid_state lat=%0d got=%h exp=%h", lat_of(k), act_st[k], exp_st[k]);
        end
        checks++;
        if (act_out[k] !== exp_out[k]) begin
          failures++;
          $display("[TB] FAIL rstmid_wout lat=%0d got=%h exp=%h", lat_of(k), act_out[k], exp_out[k]);
        end
        if (sq[i].tag != 4'd0) snap[k][sq[i].tag] = act_st[k];
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (snap[k][1] !== {1'b0, 8'd0, 3'b001} || snap[k][2] !== 12'h000) begin
        failures++;
        $display("[TB] FAIL rstmid_busy lat=%0d got=%h,%h exp=001,000", lat_of(k), snap[k][1], snap[k][2]);
      end
      checks++;
      if (snap[k][3] !== {1'b0, 8'd1, 3'b000}) begin
        failures++;
        $display("[TB] FAIL rstmid_count lat=%0d got=%h exp=008", lat_of(k), snap[k][3]);
      end
      checks++;
      if (ng[k] !== 2 || got[k][0] !== g || got[k][1] !== h) begin
        failures++;
        $display("[TB] FAIL rstmid_words lat=%0d count=%0d got=%h,%h exp=%h,%h",
                 lat_of(k), ng[k], got[k][0], got[k][1], g, h);
      end
      checks++;
      if (act_st[k] !== {1'b0, 8'd1, 3'b010}) begin
        failures++;
        $display("[TB] FAIL rstmid_end lat=%0d got=%h exp=00a", lat_of(k), act_st[k]);
      end
    end
  endtask

  task automatic test_wrap();
    begin_test();
    add_reset(2, 4'd0);
    for (int j = 0; j < 256; j++) add_group({$urandom, $urandom}, 1'b1);
    add_idle(6, 1'b1, 4'd0);
    foreach (sq[i]) begin
      drive(sq[i]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_st[k] !== exp_st[k]) begin
          failures++;
          $display("[TB] FAIL wrap_state lat=%0d got=%h exp=%h", lat_of(k), act_st[k], exp_st[k]);
        end
        checks++;
        if (act_out[k] !== exp_out[k]) begin
          failures++;
          $display("[TB] FAIL wrap_wout lat=%0d got=%h exp=%h", lat_of(k), act_out[k], exp_out[k]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (act_st[k] !== 12'h000) begin
        failures++;
        $display("[TB] FAIL wrap_end lat=%0d got=%h exp=000", lat_of(k), act_st[k]);
      end
    end
  endtask

  task automatic test_random();
    begin_test();
    add_reset(2, 4'd0);
    for (int i = 0; i < 800; i++)
      sq.push_back(mk(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) < 7),
                      3'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0), 4'd0));
    foreach (sq[i]) begin
      drive(sq[i]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (act_st[k] !== exp_st[k]) begin
          failures++;
          $display("[TB] FAIL rand_state lat=%0d got=%h exp=%h", lat_of(k), act_st[k], exp_st[k]);
        end
        checks++;
        if (act_out[k] !== exp_out[k]) begin
          failures++;
          $display("[TB] FAIL rand_wout lat=%0d got=%h exp=%h", lat_of(k), act_out[k], exp_out[k]);
        end
      end
    end
  endtask

  initial begin
    RSTL = 1'b1; WBUF_EN = 1'b0; cnt = 3'd0; rd_byte = 8'h00; W_READY = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_incomplete();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wbuf_recv.md
Name: wbuf_recv

Overview:
- Downstream consumer of the weight-buffer send controller.
- Captures the byte stream read from weight SRAM under WBUF_EN/cnt and packs LANES bytes into one wide weight word for the PE array.
- Two-entry output queue: an output register plus a skid register, drained via a valid/ready handshake.
- Reports group count, overflow and incomplete-group errors.

Parameters:
DW, 8, bits per weight byte (RDATA width)
LANES, 8, bytes per group; cnt index width IW = 3 (LANES must equal 2**IW)
RD_LAT, 1, SRAM read latency in cycles from WBUF_EN to valid RDATA (1..4)

Ports:
CLK  in  1  clock, all logic on rising edge
RSTL  in  1  synchronous reset, active-high
WBUF_EN  in  1  read strobe from the send controller; the matching byte arrives RD_LAT cycles later
cnt  in  3  lane index accompanying WBUF_EN
RDATA  in  DW  SRAM read data
W_READY  in  1  PE array accepts W_OUT
W_OUT  out  DW*LANES  packed weight word; lane i occupies bits [i*DW +: DW]
W_VALID  out  1  W_OUT holds a group
GRP_CNT  out  8  groups delivered to the output register, wraps 255->0
OVF  out  1  sticky: group completed while both output register and skid register were full
MISS  out  1  sticky: group completed with fewer than LANES distinct lanes written
BUSY  out  1  pipeline, fill register or skid register non-empty

Behaviour:
- Reset (RSTL=1 at an edge) clears: W_OUT=0, W_VALID=0, GRP_CNT=0, OVF=0, MISS=0, BUSY=0, the delay line, the fill register, the lane mask and the skid register. Reset mid-group discards everything in flight.
- Delay line: WBUF_EN and cnt are delayed RD_LAT cycles to form cap_en and cap_idx. The delay line runs regardless of queue state.
- Capture: when cap_en=1, RDATA is written into fill lane cap_idx and mask bit cap_idx is set. A rewrite of the same lane overwrites it and is not an error.
- Completion: a group completes when cap_en=1 and cap_idx=LANES-1. The completed group is the fill register including the byte captured this cycle.
  - At completion, fill and mask are cleared on the same edge. Unwritten lanes of the next group therefore read 0.
  - If the mask, including the current bit, is not all ones, set MISS. The group is still delivered.
- Queue, evaluated per edge with drain = W_VALID & W_READY:
  - Output register free (W_VALID=0 or drain): it loads from skid if skid is full, else from a completing group.
  - Completing group not taken by the output register: it goes to skid if skid will be empty after this edge. Otherwise set OVF, drop the group, and leave GRP_CNT unchanged.
  - Ordering: skid always has priority over a new group. Groups are never reordered.
  - W_VALID deasserts only on drain with nothing to load.
- Latency: from the WBUF_EN carrying cnt=LANES-1 to W_VALID=1 is RD_LAT+1 cycles, given an empty queue.
- GRP_CNT increments on every output-register load, 8-bit wrap.
- W_OUT holds stable while W_VALID=1 and W_READY=0.
- OVF and MISS clear only on reset.
- BUSY = any delay-line cap_en bit | (mask != 0) | skid full. W_VALID alone does not assert BUSY.

Test Plan:
- Basic group: RD_LAT=1, WBUF_EN for cnt 0..7 on consecutive cycles, RDATA = 8'h10+cnt, W_READY=1 -> W_VALID high 2 cycles after the cnt=7 strobe, W_OUT=64'h1716151413121110, GRP_CNT=1, OVF=0, MISS=0.
- Backpressure: three back-to-back groups with W_READY=0 -> group 1 in output, group 2 in skid, OVF=1 on the third completion, GRP_CNT=1. Then raise W_READY -> groups 1 and 2 delivered in order, GRP_CNT=2.
- Incomplete group: strobes on cnt 0,1,7 only, RDATA=8'hAA -> MISS=1, W_OUT=64'hAA000000_0000AAAA. Next full group shows no stale lanes.
- Latency sweep: repeat the basic group with RD_LAT=3 -> W_VALID 4 cycles after the cnt=7 strobe, same W_OUT.
- Reset mid-group: assert RSTL after the cnt=3 capture, then send a full group -> W_OUT contains only the new group's bytes, GRP_CNT=1, BUSY=0 on the cycle after reset.
- Wrap: deliver 256 groups with W_READY=1 -> GRP_CNT returns to 0, OVF=0.
